// File: rtl/axil_reg_intf.sv
// AXI4-Lite slave that turns bus reads and writes into register-file strobe/acknowledge accesses.
// The read and write channels are independent, and each allows one access in flight with a bounded ack wait.
module axil_reg_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [STRB_WIDTH-1:0] reg_wr_strb,
    output logic                  reg_wr_en,
    input  logic                  reg_wr_wait,
    input  logic                  reg_wr_ack,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_wait,
    input  logic                  reg_rd_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LOAD_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TO_LOAD_I);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                r_wr_state, w_wr_state_nxt;
    logic                  r_awready, w_awready_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
    logic [STRB_WIDTH-1:0] r_wr_strb, w_wr_strb_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [CNT_W-1:0]      r_wr_cnt, w_wr_cnt_nxt;
    logic                  r_bvalid, w_bvalid_nxt;

    state_t                r_rd_state, w_rd_state_nxt;
    logic                  r_arready, w_arready_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
    logic                  r_rd_en, w_rd_en_nxt;
    logic [CNT_W-1:0]      r_rd_cnt, w_rd_cnt_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;

    logic                  w_unused;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot};

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_awready;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_arready = r_arready;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = 2'b00;
    assign s_axil_rvalid  = r_rvalid;
    assign reg_wr_addr    = r_wr_addr;
    assign reg_wr_data    = r_wr_data;
    assign reg_wr_strb    = r_wr_strb;
    assign reg_wr_en      = r_wr_en;
    assign reg_rd_addr    = r_rd_addr;
    assign reg_rd_en      = r_rd_en;

    // Write channel next state: paired AW/W accept, register access with timeout, B response.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_awready_nxt  = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_wr_strb_nxt  = r_wr_strb;
        w_wr_en_nxt    = r_wr_en;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_bvalid_nxt   = r_bvalid;
        case (r_wr_state)
            ST_IDLE: begin
                if (s_axil_awvalid && s_axil_wvalid) begin
                    w_awready_nxt  = 1'b1;
                    w_wr_state_nxt = ST_READY;
                end else begin
                    w_wr_state_nxt = ST_IDLE;
                end
            end
            ST_READY: begin
                if (s_axil_awvalid && s_axil_wvalid) begin
                    w_wr_addr_nxt  = s_axil_awaddr;
                    w_wr_data_nxt  = s_axil_wdata;
                    w_wr_strb_nxt  = s_axil_wstrb;
                    w_wr_en_nxt    = 1'b1;
                    w_wr_cnt_nxt   = TO_LOAD;
                    w_wr_state_nxt = ST_ACCESS;
                end else begin
                    w_wr_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Ack wins over an expiring counter in the same cycle.
                if (reg_wr_ack || (TO_EN && (r_wr_cnt == CNT_ZERO) && !reg_wr_wait)) begin
                    w_wr_en_nxt    = 1'b0;
                    w_bvalid_nxt   = 1'b1;
                    w_wr_state_nxt = ST_RESP;
                end else if (reg_wr_wait) begin
                    w_wr_cnt_nxt = TO_LOAD;
                end else if (r_wr_cnt != CNT_ZERO) begin
                    w_wr_cnt_nxt = r_wr_cnt - CNT_ONE;
                end else begin
                    w_wr_cnt_nxt = r_wr_cnt;
                end
            end
            ST_RESP: begin
                if (s_axil_bready) begin
                    w_bvalid_nxt   = 1'b0;
                    w_wr_state_nxt = ST_IDLE;
                end else begin
                    w_bvalid_nxt = 1'b1;
                end
            end
            default: begin
                w_wr_en_nxt    = 1'b0;
                w_bvalid_nxt   = 1'b0;
                w_wr_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read channel next state: AR accept, register access with timeout, R response.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = 1'b0;
        w_rd_addr_nxt  = r_rd_addr;
        w_rd_en_nxt    = r_rd_en;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_rvalid_nxt   = r_rvalid;
        w_rdata_nxt    = r_rdata;
        case (r_rd_state)
            ST_IDLE: begin
                if (s_axil_arvalid) begin
                    w_arready_nxt  = 1'b1;
                    w_rd_state_nxt = ST_READY;
                end else begin
                    w_rd_state_nxt = ST_IDLE;
                end
            end
            ST_READY: begin
                if (s_axil_arvalid) begin
                    w_rd_addr_nxt  = s_axil_araddr;
                    w_rd_en_nxt    = 1'b1;
                    w_rd_cnt_nxt   = TO_LOAD;
                    w_rd_state_nxt = ST_ACCESS;
                end else begin
                    w_rd_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (reg_rd_ack) begin
                    w_rd_en_nxt    = 1'b0;
                    w_rvalid_nxt   = 1'b1;
                    w_rdata_nxt    = reg_rd_data;
                    w_rd_state_nxt = ST_RESP;
                end else if (TO_EN && (r_rd_cnt == CNT_ZERO) && !reg_rd_wait) begin
                    w_rd_en_nxt    = 1'b0;
                    w_rvalid_nxt   = 1'b1;
                    w_rdata_nxt    = {DATA_WIDTH{1'b0}};
                    w_rd_state_nxt = ST_RESP;
                end else if (reg_rd_wait) begin
                    w_rd_cnt_nxt = TO_LOAD;
                end else if (r_rd_cnt != CNT_ZERO) begin
                    w_rd_cnt_nxt = r_rd_cnt - CNT_ONE;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt;
                end
            end
            ST_RESP: begin
                if (s_axil_rready) begin
                    w_rvalid_nxt   = 1'b0;
                    w_rd_state_nxt = ST_IDLE;
                end else begin
                    w_rvalid_nxt = 1'b1;
                end
            end
            default: begin
                w_rd_en_nxt    = 1'b0;
                w_rvalid_nxt   = 1'b0;
                w_rd_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write channel state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= ST_IDLE;
            r_awready  <= 1'b0;
            r_wr_addr  <= {ADDR_WIDTH{1'b0}};
            r_wr_data  <= {DATA_WIDTH{1'b0}};
            r_wr_strb  <= {STRB_WIDTH{1'b0}};
            r_wr_en    <= 1'b0;
            r_wr_cnt   <= CNT_ZERO;
            r_bvalid   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_awready  <= w_awready_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_wr_strb  <= w_wr_strb_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_bvalid   <= w_bvalid_nxt;
        end
    end

    // Read channel state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= ST_IDLE;
            r_arready  <= 1'b0;
            r_rd_addr  <= {ADDR_WIDTH{1'b0}};
            r_rd_en    <= 1'b0;
            r_rd_cnt   <= CNT_ZERO;
            r_rvalid   <= 1'b0;
            r_rdata    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_axil_reg_intf.sv
// Directed bench for axil_reg_intf: drives inputs 1 ns after each rising edge and checks registered outputs there.
module tb_axil_reg_intf;

    logic        clk;
    logic        rst;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_en;
    logic        wr_wait;
    logic        wr_ack;
    logic [15:0] rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_wait;
    logic        rd_ack;

    int n_cmp;
    int n_err;
    int n;

    axil_reg_intf #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .STRB_WIDTH(4),
        .TIMEOUT   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (awaddr),
        .s_axil_awprot (awprot),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata  (wdata),
        .s_axil_wstrb  (wstrb),
        .s_axil_wvalid (wvalid),
        .s_axil_wready (wready),
        .s_axil_bresp  (bresp),
        .s_axil_bvalid (bvalid),
        .s_axil_bready (bready),
        .s_axil_araddr (araddr),
        .s_axil_arprot (arprot),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata  (rdata),
        .s_axil_rresp  (rresp),
        .s_axil_rvalid (rvalid),
        .s_axil_rready (rready),
        .reg_wr_addr   (wr_addr),
        .reg_wr_data   (wr_data),
        .reg_wr_strb   (wr_strb),
        .reg_wr_en     (wr_en),
        .reg_wr_wait   (wr_wait),
        .reg_wr_ack    (wr_ack),
        .reg_rd_addr   (rd_addr),
        .reg_rd_en     (rd_en),
        .reg_rd_data   (rd_data),
        .reg_rd_wait   (rd_wait),
        .reg_rd_ack    (rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Address phase of a read; returns during the first cycle with reg_rd_en high.
    task automatic rd_addr_phase(input logic [15:0] a);
        araddr  = a;
        arvalid = 1'b1;
        step();
        check_eq("arready_pulse", {31'd0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        check_eq("arready_low", {31'd0, arready}, 32'd0);
        check_eq("rd_en_rise", {31'd0, rd_en}, 32'd1);
        check_eq("rd_addr", {16'd0, rd_addr}, {16'd0, a});
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        awaddr  = 16'h0000;
        awprot  = 3'b000;
        awvalid = 1'b0;
        wdata   = 32'h0000_0000;
        wstrb   = 4'h0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = 16'h0000;
        arprot  = 3'b000;
        arvalid = 1'b0;
        rready  = 1'b0;
        wr_wait = 1'b0;
        wr_ack  = 1'b0;
        rd_data = 32'h0000_0000;
        rd_wait = 1'b0;
        rd_ack  = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_outputs", {20'd0, awready, wready, bvalid, arready, rvalid, wr_en, rd_en,
                                 bresp, rresp, 1'b0}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);

        // Single write, ack in the second enable cycle.
        awaddr = 16'h0004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        check_eq("aw_w_ready", {30'd0, awready, wready}, 32'd3);
        check_eq("wr_en_not_yet", {31'd0, wr_en}, 32'd0);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("aw_w_ready_drop", {30'd0, awready, wready}, 32'd0);
        check_eq("wr_en_c1", {31'd0, wr_en}, 32'd1);
        check_eq("wr_addr", {16'd0, wr_addr}, 32'h0000_0004);
        check_eq("wr_data", wr_data, 32'hDEAD_BEEF);
        step();
        check_eq("wr_en_c2", {31'd0, wr_en}, 32'd1);
        check_eq("bvalid_early", {31'd0, bvalid}, 32'd0);
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        check_eq("wr_en_drop", {31'd0, wr_en}, 32'd0);
        check_eq("bvalid_rise", {31'd0, bvalid}, 32'd1);
        check_eq("bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check_eq("bvalid_clear", {31'd0, bvalid}, 32'd0);

        // W without AW is never accepted.
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("w_only_noready", {30'd0, awready, wready}, 32'd0);
        end
        wvalid = 1'b0;

        // Read, ack with data in the second enable cycle.
        rd_addr_phase(16'h1000);
        step();
        rd_ack = 1'b1; rd_data = 32'h1234_5678;
        step();
        rd_ack = 1'b0; rd_data = 32'hFFFF_FFFF;
        check_eq("rd_en_drop", {31'd0, rd_en}, 32'd0);
        check_eq("rvalid_rise", {31'd0, rvalid}, 32'd1);
        check_eq("rdata_ack", rdata, 32'h1234_5678);
        check_eq("rresp", {30'd0, rresp}, 32'd0);
        step();
        check_eq("rvalid_hold", {31'd0, rvalid}, 32'd1);
        check_eq("rdata_stable", rdata, 32'h1234_5678);
        check_eq("arready_single", {31'd0, arready}, 32'd0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check_eq("rvalid_clear", {31'd0, rvalid}, 32'd0);

        // Timeout without ack: four enable cycles, then zero data.
        rd_addr_phase(16'h0008);
        n = 0;
        while (rd_en && n < 40) begin
            n++;
            step();
        end
        check_eq("to_en_cycles", n, 32'd4);
        check_eq("to_rvalid", {31'd0, rvalid}, 32'd1);
        check_eq("to_rdata", rdata, 32'd0);
        rready = 1'b1; step(); rready = 1'b0;

        // Wait held for ten enable cycles stretches the access to 10+4.
        rd_wait = 1'b1;
        rd_addr_phase(16'h000C);
        n = 0;
        while (rd_en && n < 40) begin
            n++;
            if (n == 11) rd_wait = 1'b0;
            step();
        end
        rd_wait = 1'b0;
        check_eq("wait_en_cycles", n, 32'd14);
        check_eq("wait_rvalid", {31'd0, rvalid}, 32'd1);
        rready = 1'b1; step(); rready = 1'b0;

        // Ack in the same cycle the counter expires is taken as an ack.
        rd_addr_phase(16'h0010);
        step(); step(); step();
        rd_ack = 1'b1; rd_data = 32'hA5A5_A5A5;
        step();
        rd_ack = 1'b0; rd_data = 32'h0000_0000;
        check_eq("ack_at_to_rvalid", {31'd0, rvalid}, 32'd1);
        check_eq("ack_at_to_rdata", rdata, 32'hA5A5_A5A5);
        rready = 1'b1; step(); rready = 1'b0;

        // B backpressure while a second write is presented.
        awaddr = 16'h0014; wdata = 32'h0000_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step(); step();
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        check_eq("bp_bvalid_rise", {31'd0, bvalid}, 32'd1);
        awaddr = 16'h0018; wdata = 32'h0000_0002;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
            check_eq("bp_no_accept", {30'd0, awready, wr_en}, 32'd0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check_eq("bp_bvalid_clear", {31'd0, bvalid}, 32'd0);
        check_eq("bp_ready_after_hs", {31'd0, awready}, 32'd0);
        step();
        check_eq("bp_second_ready", {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("bp_second_en", {31'd0, wr_en}, 32'd1);
        check_eq("bp_second_addr", {16'd0, wr_addr}, 32'h0000_0018);
        check_eq("bp_second_data", wr_data, 32'h0000_0002);
        wr_ack = 1'b1; bready = 1'b1;
        step();
        wr_ack = 1'b0;
        step();
        bready = 1'b0;

        // Concurrent write and read, completing independently.
        awaddr = 16'h0020; wdata = 32'h0000_00FF; wstrb = 4'h3;
        araddr = 16'h0030;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        check_eq("cc_readies", {29'd0, awready, wready, arready}, 32'd7);
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("cc_both_en", {30'd0, wr_en, rd_en}, 32'd3);
        check_eq("cc_strb", {28'd0, wr_strb}, 32'h0000_0003);
        wr_ack = 1'b1; bready = 1'b1;
        step();
        wr_ack = 1'b0;
        check_eq("cc_wr_done", {29'd0, wr_en, bvalid, rd_en}, 32'd3);
        step();
        bready = 1'b0;
        check_eq("cc_b_clear", {30'd0, bvalid, rd_en}, 32'd1);
        rd_ack = 1'b1; rd_data = 32'h0BAD_F00D;
        step();
        rd_ack = 1'b0;
        check_eq("cc_rd_done", {30'd0, rd_en, rvalid}, 32'd1);
        check_eq("cc_rdata", rdata, 32'h0BAD_F00D);
        rready = 1'b1; step(); rready = 1'b0;

        // Reset in the middle of concurrent accesses.
        awaddr = 16'h0040; wdata = 32'h5555_5555; wstrb = 4'hF; araddr = 16'h0050;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step(); step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("mid_en_high", {30'd0, wr_en, rd_en}, 32'd3);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ctrl", {25'd0, awready, arready, bvalid, rvalid, wr_en, rd_en, 1'b0}, 32'd0);
        check_eq("mid_rst_wr_addr", {16'd0, wr_addr}, 32'd0);
        check_eq("mid_rst_wr_data", wr_data, 32'd0);
        step();
        rst = 1'b0;
        wr_ack = 1'b1; rd_ack = 1'b1; bready = 1'b1; rready = 1'b1;
        step(); step();
        wr_ack = 1'b0; rd_ack = 1'b0; bready = 1'b0; rready = 1'b0;
        check_eq("post_rst_no_resp", {28'd0, bvalid, rvalid, wr_en, rd_en}, 32'd0);
        step();
        check_eq("post_rst_quiet", {30'd0, bvalid, rvalid}, 32'd0);

        // Next write after reset proceeds normally.
        awaddr = 16'h0044; wdata = 32'h1122_3344; wstrb = 4'hC;
        awvalid = 1'b1; wvalid = 1'b1;
        step(); step();
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("post_rst_addr", {16'd0, wr_addr}, 32'h0000_0044);
        check_eq("post_rst_data", wr_data, 32'h1122_3344);
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        check_eq("post_rst_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1'b1; step(); bready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_reg_intf.md
Name: axil_reg_intf

Overview:
AXI4-Lite slave front end that turns AXI-Lite reads and writes into a simple register-access strobe/acknowledge interface. It has independent read and write channels. Each channel handles one outstanding transaction, and a timeout guarantees the bus is never hung. It sits between the AXI-Lite interconnect and a control-register file; the register file decodes the address and returns read data or a write acknowledgement.

Parameters:
DATA_WIDTH, 32, AXI-Lite and register data width (bits).
ADDR_WIDTH, 16, byte address width.
STRB_WIDTH, DATA_WIDTH/8, write-strobe width; must equal DATA_WIDTH/8.
TIMEOUT, 4, cycles an access may wait for ack before forced completion; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awprot  in  3  ignored
s_axil_awvalid  in  1  AW valid
s_axil_awready  out  1  AW ready
s_axil_wdata  in  DATA_WIDTH  write data
s_axil_wstrb  in  STRB_WIDTH  byte strobes
s_axil_wvalid  in  1  W valid
s_axil_wready  out  1  W ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  B valid
s_axil_bready  in  1  B ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arprot  in  3  ignored
s_axil_arvalid  in  1  AR valid
s_axil_arready  out  1  AR ready
s_axil_rdata  out  DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  R valid
s_axil_rready  in  1  R ready
reg_wr_addr  out  ADDR_WIDTH  captured write byte address, unmodified
reg_wr_data  out  DATA_WIDTH  captured write data
reg_wr_strb  out  STRB_WIDTH  captured strobes
reg_wr_en  out  1  write request
reg_wr_wait  in  1  register side extends write (freezes timeout)
reg_wr_ack  in  1  write done
reg_rd_addr  out  ADDR_WIDTH  captured read byte address
reg_rd_en  out  1  read request
reg_rd_data  in  DATA_WIDTH  read data, valid with reg_rd_ack
reg_rd_wait  in  1  register side extends read (freezes timeout)
reg_rd_ack  in  1  read done

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- Reset: all outputs are 0. Any in-flight transaction is dropped; no response is issued for it.
- All outputs are registered.
- Write channel, idle means no write active and bvalid low:
  - Accept only when awvalid and wvalid are both high. Assert awready and wready together for exactly one cycle.
  - At that edge, capture awaddr, wdata and wstrb into reg_wr_*.
  - reg_wr_en rises the following cycle and stays high, with addr/data/strb stable, through the first cycle in which reg_wr_ack is sampled high.
  - Timeout counter loads TIMEOUT-1 at accept. It decrements each cycle reg_wr_en is high, ack is low and wait is low. When reg_wr_wait is high it reloads to TIMEOUT-1.
  - Completion occurs on ack, or on counter==0 with wait low (TIMEOUT>0). On completion, reg_wr_en drops at the next edge and bvalid rises at the same edge.
  - bresp is always 2'b00 (OKAY), timeout included.
  - bvalid holds until bready. A new AW/W is accepted only in the cycle after the bvalid&bready handshake or later.
  - AW without W, or W without AW: no acceptance; both ready signals stay low.
- Read channel, idle means no read active and rvalid low:
  - On arvalid, pulse arready for one cycle and capture araddr into reg_rd_addr.
  - reg_rd_en behaves like reg_wr_en, and the same timeout rules apply with reg_rd_wait.
  - On ack, rdata takes reg_rd_data. On timeout, rdata = 0.
  - rresp is always 2'b00.
  - rvalid rises at the edge that ends the access and holds until rready. rdata is stable while rvalid is high.
- Read and write channels are fully independent and may be active simultaneously.
- Ack received while the corresponding en is low is ignored.
- Ack arriving in the same cycle the timeout expires is treated as ack: read data comes from reg_rd_data.
- TIMEOUT=0: en stays high until ack, with no forced completion.

Test Plan:
- Write addr 0x0004, data 0xDEADBEEF, strb 0xF, ack one cycle after en rises: awready and wready pulse together; reg_wr_en high for 2 cycles with addr 0x0004 and data 0xDEADBEEF; bvalid next cycle; bresp 00.
- Read addr 0x1000, reg_rd_data=0x12345678 with ack on 2nd en cycle: rvalid with rdata 0x12345678, rresp 00; arready pulsed once.
- No ack, TIMEOUT=4: reg_rd_en high for exactly 4 cycles, then rvalid with rdata 0. Same case with reg_rd_wait held 10 cycles: en stays high 10+4 cycles.
- Hold bready low for 5 cycles after bvalid while a second AW/W is presented: bvalid stays high; second write accepted only after the handshake; reg_wr_en low meanwhile.
- Concurrent read and write issued in the same cycle: both en signals assert together and complete independently; strobe 0x3 is passed through unchanged.
- Assert rst mid-access (en high): all outputs 0 immediately, with no bvalid/rvalid afterward; the next transaction is accepted normally.
